// File: rtl/reg_bank_dump_ctrl_if.sv
// Bundle between the dump controller, the register bank's first read port
// and the debug TX link.
//   master : the dump controller (drives the bank address and the TX byte)
//   slave  : the bank / transmitter side
interface reg_bank_dump_ctrl_if;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [4:0]  bank_r1;
   logic [31:0] bank_d1;

   modport master (
      output tx_data,
      output tx_valid,
      output bank_r1,
      input  tx_ready,
      input  bank_d1
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      input  bank_r1,
      output tx_ready,
      output bank_d1
   );
endinterface

// File: rtl/reg_bank_dump_ctrl.sv
// Debug dump controller: once the pipeline is halted it borrows bank read
// port r1, walks registers 0..NREGS-1 and streams a header byte followed by
// every register (MSB first) over a valid/ready byte link.
module reg_bank_dump_ctrl #(
   parameter int         NREGS    = 32,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        dump_start,
   input  logic                        pipe_halted,
   input  logic [4:0]                  pipe_r1,
   reg_bank_dump_ctrl_if.master        bus,
   output logic                        busy,
   output logic                        done,
   output logic                        abort
);

   localparam logic [4:0] LAST_IDX = 5'(NREGS - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_HALT = 3'd1,
      S_HDR       = 3'd2,
      S_ADDR      = 3'd3,
      S_SEND      = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] shift_q, shift_d;
   logic [1:0]  bcnt_q, bcnt_d;
   logic        abort_q, abort_d;

   // State and datapath registers; reset returns everything to an idle port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= 5'd0;
         shift_q <= 32'd0;
         bcnt_q  <= 2'd0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         bcnt_q  <= bcnt_d;
         abort_q <= abort_d;
      end
   end

   // Next-state logic; losing the halt while the dump owns the port cancels it.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      bcnt_d  = bcnt_q;
      abort_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dump_start) begin
               state_d = S_WAIT_HALT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_HALT: begin
            if (pipe_halted) begin
               state_d = S_HDR;
            end else begin
               state_d = S_WAIT_HALT;
            end
         end
         S_HDR: begin
            if (!pipe_halted) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end else if (bus.tx_ready) begin
               idx_d   = 5'd0;
               state_d = S_ADDR;
            end else begin
               state_d = S_HDR;
            end
         end
         S_ADDR: begin
            if (!pipe_halted) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end else begin
               shift_d = bus.bank_d1;
               bcnt_d  = 2'd0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (!pipe_halted) begin
               state_d = S_IDLE;
               abort_d = 1'b1;
            end else if (bus.tx_ready) begin
               shift_d = {shift_q[23:0], 8'h00};
               bcnt_d  = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  if (idx_q == LAST_IDX) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q + 5'd1;
                     state_d = S_ADDR;
                  end
               end else begin
                  state_d = S_SEND;
               end
            end else begin
               state_d = S_SEND;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs decoded from the state flops; only the r1 address is a live mux.
   always_comb begin
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.bank_r1  = idx_q;
      busy         = 1'b1;
      done         = 1'b0;
      abort        = abort_q;
      case (state_q)
         S_IDLE: begin
            busy        = 1'b0;
            bus.bank_r1 = pipe_r1;
         end
         S_WAIT_HALT: begin
            bus.bank_r1 = pipe_r1;
         end
         S_HDR: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = HDR_BYTE;
         end
         S_ADDR: begin
            bus.tx_valid = 1'b0;
         end
         S_SEND: begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = shift_q[31:24];
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy        = 1'b0;
            bus.bank_r1 = pipe_r1;
         end
      endcase
   end

endmodule

// File: tb/tb_reg_bank_dump_ctrl.sv
// Bench for reg_bank_dump_ctrl: a behavioural bank plus a frame/timeline
// reference model; randomized bank contents, ready patterns and pipe_r1.
module tb_reg_bank_dump_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       dump_start;
   logic       pipe_halted;
   logic [4:0] pipe_r1;
   logic       busy, done, abort;

   reg_bank_dump_ctrl_if bus();

   logic [31:0] bank_mem [0:31];
   bit          rdy [0:1023];
   logic [7:0]  exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   reg_bank_dump_ctrl #(.NREGS(32), .HDR_BYTE(8'hA5)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .dump_start  (dump_start),
      .pipe_halted (pipe_halted),
      .pipe_r1     (pipe_r1),
      .bus         (bus),
      .busy        (busy),
      .done        (done),
      .abort       (abort)
   );

   always #5 clk = ~clk;

   // behavioural bank read port: combinational from the address
   assign bus.bank_d1 = bank_mem[bus.bank_r1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // expected frame: header, then each register MSB first
   function automatic void build_frame();
      logic [31:0] w;
      exp_q.delete();
      exp_q.push_back(8'hA5);
      for (int r = 0; r < 32; r++) begin
         w = bank_mem[r];
         for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
      end
   endfunction

   // timeline: header waits for ready, then per register one address cycle
   // followed by four bytes that each wait for a ready cycle
   function automatic int exp_done(input int hdr);
      int c = hdr;
      while (c < 1023 && !rdy[c]) c++;
      for (int r = 0; r < 32; r++) begin
         c++;
         for (int b = 0; b < 4; b++) begin
            c++;
            while (c < 1023 && !rdy[c]) c++;
         end
      end
      return c + 1;
   endfunction

   // mode 0: plain, 1: drop halt in SEND of reg 7, 2: reset mid reg 20,
   // 3: extra dump_start pulses during the dump
   task automatic run_dump(input int halt_delay, input int mode);
      int cyc = 0;
      int hs = 0;
      int hdr, edone;
      bit fin = 0;
      bit ab = 0;
      build_frame();
      hdr   = ((halt_delay == 0) ? 1 : halt_delay) + 1;
      edone = exp_done(hdr);
      @(negedge clk);
      dump_start  = 1'b1;
      pipe_halted = (halt_delay == 0);
      bus.tx_ready = 1'b1;
      @(posedge clk);
      while (!fin && cyc < 1000) begin
         #1;
         cyc++;
         dump_start = (mode == 3 && cyc >= 40 && cyc < 43);
         pipe_r1    = 5'($urandom_range(0, 31));
         if (halt_delay > 0) pipe_halted = (cyc >= halt_delay);
         #1;
         if (ab) begin
            chk("abort_pulse", abort, 1'b1);
            chk("abort_valid", bus.tx_valid, 1'b0);
            chk("abort_busy", busy, 1'b0);
            chk("abort_r1", bus.bank_r1, pipe_r1);
            chk("abort_nodone", done, 1'b0);
            @(posedge clk);
            #1;
            chk("abort_once", abort, 1'b0);
            chk("abort_idle", busy, 1'b0);
            fin = 1;
         end else begin
            if (cyc < hdr) begin
               chk("passthru_r1", bus.bank_r1, pipe_r1);
               chk("wait_valid", bus.tx_valid, 1'b0);
            end
            chk("busy", busy, 1'b1);
            chk("no_abort", abort, 1'b0);
            if (done) begin
               chk("done_cycle", cyc, edone);
               chk("frame_len", hs, 129);
               @(posedge clk);
               #1;
               chk("busy_after", busy, 1'b0);
               chk("done_pulse", done, 1'b0);
               fin = 1;
            end else begin
               bus.tx_ready = rdy[cyc];
               if (bus.tx_valid) begin
                  if (exp_q.size() > 0) chk("byte", bus.tx_data, exp_q[0]);
                  else chk("extra_byte", bus.tx_valid, 1'b0);
                  if (mode == 1 && hs == 30) begin
                     pipe_halted  = 1'b0;
                     bus.tx_ready = 1'b0;
                     ab = 1;
                  end else if (mode == 2 && hs == 83) begin
                     #2 reset_n = 1'b0;
                     #1;
                     chk("rst_valid", bus.tx_valid, 1'b0);
                     chk("rst_data", bus.tx_data, 8'h00);
                     chk("rst_busy", busy, 1'b0);
                     chk("rst_done", done, 1'b0);
                     chk("rst_abort", abort, 1'b0);
                     chk("rst_r1", bus.bank_r1, pipe_r1);
                     fin = 1;
                  end else if (bus.tx_ready) begin
                     void'(exp_q.pop_front());
                     hs++;
                  end
               end
            end
         end
         if (!fin) @(posedge clk);
      end
      if (!fin) chk("timeout", 32'd0, 32'd1);
      @(negedge clk);
      dump_start   = 1'b0;
      pipe_halted  = 1'b1;
      bus.tx_ready = 1'b1;
   endtask

   task automatic rand_bank();
      for (int r = 0; r < 32; r++) bank_mem[r] = $urandom;
   endtask

   task automatic set_rdy(input int kind);
      for (int i = 0; i < 1024; i++) begin
         case (kind)
            0:       rdy[i] = 1'b1;
            1:       rdy[i] = (i % 2 == 1);
            default: rdy[i] = ($urandom_range(0, 3) != 0);
         endcase
      end
   endtask

   initial begin
      reset_n      = 1'b0;
      dump_start   = 1'b0;
      pipe_halted  = 1'b0;
      pipe_r1      = 5'd9;
      bus.tx_ready = 1'b0;
      for (int r = 0; r < 32; r++) bank_mem[r] = 32'd0;
      #1;
      chk("reset_valid", bus.tx_valid, 1'b0);
      chk("reset_data", bus.tx_data, 8'h00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_abort", abort, 1'b0);
      chk("reset_r1", bus.bank_r1, 5'd9);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      pipe_r1 = 5'd17;
      #1;
      chk("idle_r1", bus.bank_r1, 5'd17);

      // directed contents, ready tied high
      bank_mem[3] = 32'd30;
      bank_mem[5] = 32'd40;
      set_rdy(0);
      run_dump(0, 0);

      // ready toggling every cycle
      set_rdy(1);
      run_dump(0, 0);

      // halt arrives 10 cycles after the request
      rand_bank();
      set_rdy(0);
      run_dump(10, 0);

      // abort in register 7, then a fresh dump from the header
      rand_bank();
      set_rdy(2);
      run_dump(0, 1);
      repeat (2) @(negedge clk);
      run_dump(0, 0);

      // async reset mid register 20, then a complete dump
      rand_bank();
      set_rdy(2);
      run_dump(0, 2);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rand_bank();
      run_dump(0, 0);

      // re-pulsed request inside a dump is ignored
      rand_bank();
      set_rdy(2);
      run_dump(0, 3);
      repeat (4) @(posedge clk);
      #1;
      chk("no_second_frame", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
